ram_march_bist: RTL and testbench
=================================

# ram_march_bist

March C- built-in self-test controller that drives one port of the team's dual-port RAM and checks what it reads back. It connects to a single RAM port (clock, write enable, read enable, address, write data, read data). It runs the full 10N March C- sequence on start and reports pass/fail, with first-failure diagnostics. It sits between a test/boot sequencer and the RAM instance and owns that port exclusively while busy.

## Interface
- DATA_WIDTH, 8, RAM word width
- DEPTH, 256, number of RAM words tested (any value ≥2; need not be a power of two); AW = $clog2(DEPTH)

- clk  in  1  single clock, also drives the RAM port clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin test; sampled only in IDLE
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end (pass or abort)
- pass  out  1  result of last completed test; held until next start
- fail  out  1  sticky mismatch flag; cleared on start
- fail_elem  out  3  March element (1..5) of first mismatch
- fail_addr  out  AW  address of first mismatch
- fail_data  out  DATA_WIDTH  word actually read at first mismatch
- ram_wr_en  out  1  RAM write enable
- ram_rd_en  out  1  RAM read enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data (valid the cycle after ram_rd_en was driven)

## Operation
- All outputs are registered; reset value of every output is 0.
- March C- elements; Z = all-zeros, O = all-ones, both DATA_WIDTH wide:
  - E0: ascending w Z
  - E1: ascending (r Z, w O)
  - E2: ascending (r O, w Z)
  - E3: descending (r Z, w O)
  - E4: descending (r O, w Z)
  - E5: ascending r Z
- Ascending is 0..DEPTH-1; descending is DEPTH-1..0. Addresses ≥ DEPTH are never driven.
- FSM states:
  - IDLE: start=1 → WRITE (E0, addr 0), clear fail/pass/fail_*.
  - WRITE: one write per cycle; after DEPTH-1 → READ (E1, addr 0).
  - READ: drive rd_en for the current address → WRITE_CMP.
  - WRITE_CMP: drive wr_en with the element's write value and compare ram_rdata against the expected value. Last address of the element → READ with next element's start address; last address of E4 → READ (E5). Otherwise → READ at next address.
  - E5 uses READ → CMP (no RAM strobes in CMP).
  - After the last CMP → IDLE with done=1 and pass=1.
- Mismatch in WRITE_CMP/CMP:
  - Capture fail_elem, fail_addr, fail_data; set fail=1.
  - Go to IDLE with done=1, pass=0 (abort). The write already being driven in that cycle still completes.
- rd_en and wr_en are never high together. Both are 0 in IDLE and CMP.
- start while busy is ignored. start held high in IDLE re-triggers a new run after done.
- Reset mid-test: immediate return to IDLE, all outputs 0, RAM strobes dropped. RAM contents are undefined afterwards.

## Timing
- start sampled high at edge k → busy=1, ram_wr_en=1, ram_addr=0, ram_wdata=Z during cycle k+1.
- Read issued in cycle c → compared in cycle c+1 → result registered at edge ending c+1.
- Passing run: busy high for exactly 11·DEPTH cycles (E0: DEPTH; E1–E4: 2·DEPTH each; E5: 2·DEPTH).
- done rises in the first cycle busy is 0 and lasts one cycle.
- Failing run: done arrives one cycle after the mismatching compare cycle.

## Structure
- Package ram_march_bist_pkg: state enum (IDLE, WRITE, READ, WRITE_CMP, CMP), element encoding E0..E5, per-element direction / read-value / write-value constant functions.
- Sub-module ram_march_addr_gen:
  - AW-bit up/down address counter with load-to-start (0 or DEPTH-1) and a `last` flag.
  - Handles non-power-of-two DEPTH.

## Test plan
- Fault-free behavioural RAM, DEPTH=16, W=8: pulse start → busy 176 cycles, first cycle wr addr 0 data 0x00, done pulse, pass=1, fail=0.
- Stuck-at-1 on bit 3 at addr 5 → fail_elem=1, fail_addr=5, fail_data=0x08, pass=0, done one cycle after compare.
- Stuck-at-0 on bit 0 at addr 15 (DEPTH=16) → fail_elem=2, fail_addr=15, fail_data=0xFE.
- Coupling fault, write of 0xFF to addr 3 forces addr 2 to 0x00 → fail_elem=2, fail_addr=2, fail_data=0x00.
- rst_n low at cycle 50 of a run → all outputs 0 asynchronously; restart then gives pass=1 after 176 cycles. Pulsing start mid-run changes nothing.
- DEPTH=10: ram_addr never exceeds 9; busy lasts 110 cycles; E3 starts at addr 9; pass=1.

Source files
------------

// File: rtl/ram_march_bist_pkg.sv
// Shared types and per-element March C- attributes for the RAM BIST controller.
package ram_march_bist_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        WRITE_CMP = 3'd3,
        CMP       = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    function automatic logic elem_descending(input elem_e e);
        return (e == E3) || (e == E4);
    endfunction

    // Data patterns are all-zeros or all-ones, so a single bit describes them.
    function automatic logic elem_read_ones(input elem_e e);
        return (e == E2) || (e == E4);
    endfunction

    function automatic logic elem_write_ones(input elem_e e);
        return (e == E1) || (e == E3);
    endfunction

endpackage

// File: rtl/ram_march_addr_gen.sv
// Up/down address counter for the March BIST; loads to 0 or DEPTH-1 and flags the
// last address of the current sweep, so non-power-of-two depths never overrun.
module ram_march_addr_gen #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          load_down,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    logic down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            down <= load_down;
            addr <= load_down ? MAX_ADDR : '0;
        end else if (step) begin
            addr <= down ? (addr - ONE) : (addr + ONE);
        end
    end

    assign last = down ? (addr == '0) : (addr == MAX_ADDR);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST controller owning one RAM port; runs the 10N sequence on start
// and reports pass/fail with the element, address and data of the first mismatch.
module ram_march_bist
    import ram_march_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [2:0]            fail_elem,
    output logic [AW-1:0]         fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_e state, state_n;
    elem_e  elem, elem_n;

    logic                  ag_load, ag_load_down, ag_step, ag_last;
    logic [AW-1:0]         addr;
    logic                  busy_n, done_n, pass_n, fail_n, rd_n, wr_n;
    logic [2:0]            fail_elem_n;
    logic [AW-1:0]         fail_addr_n;
    logic [DATA_WIDTH-1:0] fail_data_n, wdata_n, exp_rdata;
    logic                  mismatch;

    ram_march_addr_gen #(
        .DEPTH(DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .load_down(ag_load_down),
        .step     (ag_step),
        .addr     (addr),
        .last     (ag_last)
    );

    assign ram_addr  = addr;
    assign exp_rdata = {DATA_WIDTH{elem_read_ones(elem)}};
    assign mismatch  = (ram_rdata != exp_rdata);

    // RAM strobes and status are computed for the upcoming cycle and registered,
    // so every output changes only on a clock edge.
    always_comb begin
        state_n      = state;
        elem_n       = elem;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        done_n       = 1'b0;
        pass_n       = pass;
        fail_n       = fail;
        fail_elem_n  = fail_elem;
        fail_addr_n  = fail_addr;
        fail_data_n  = fail_data;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = WRITE;
                    elem_n      = E0;
                    ag_load     = 1'b1;
                    pass_n      = 1'b0;
                    fail_n      = 1'b0;
                    fail_elem_n = '0;
                    fail_addr_n = '0;
                    fail_data_n = '0;
                end
            end
            WRITE: begin
                if (ag_last) begin
                    state_n      = READ;
                    elem_n       = E1;
                    ag_load      = 1'b1;
                    ag_load_down = elem_descending(E1);
                end else begin
                    ag_step = 1'b1;
                end
            end
            READ: begin
                state_n = (elem == E5) ? CMP : WRITE_CMP;
            end
            WRITE_CMP, CMP: begin
                if (mismatch) begin
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    pass_n      = 1'b0;
                    fail_n      = 1'b1;
                    fail_elem_n = elem;
                    fail_addr_n = addr;
                    fail_data_n = ram_rdata;
                end else if (ag_last) begin
                    if (elem == E5) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end else begin
                        elem_n       = elem_e'(elem + 3'd1);
                        state_n      = READ;
                        ag_load      = 1'b1;
                        ag_load_down = elem_descending(elem_n);
                    end
                end else begin
                    ag_step = 1'b1;
                    state_n = READ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n  = (state_n != IDLE);
        rd_n    = (state_n == READ);
        wr_n    = (state_n == WRITE) || (state_n == WRITE_CMP);
        wdata_n = wr_n ? {DATA_WIDTH{elem_write_ones(elem_n)}} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            elem      <= E0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_elem <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_wdata <= '0;
        end else begin
            state     <= state_n;
            elem      <= elem_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            fail      <= fail_n;
            fail_elem <= fail_elem_n;
            fail_addr <= fail_addr_n;
            fail_data <= fail_data_n;
            ram_wr_en <= wr_n;
            ram_rd_en <= rd_n;
            ram_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist: two instances (DEPTH 16 with fault-injecting
// RAM, DEPTH 10 fault-free) checked against a behavioural March C- reference model.
module tb_ram_march_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic       busy16, done16, pass16, fail16, wr16, rd16;
    logic [2:0] fe16;
    logic [3:0] fa16, addr16;
    logic [7:0] fd16, wdata16, rdata16;
    logic       busy10, done10, pass10, fail10, wr10, rd10;
    logic [2:0] fe10;
    logic [3:0] fa10, addr10;
    logic [7:0] fd10, wdata10, rdata10;
    logic       start16, start10;

    assign start16 = sel ? 1'b0 : start;
    assign start10 = sel ? start : 1'b0;

    ram_march_bist #(.DATA_WIDTH(8), .DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16),
        .pass(pass16), .fail(fail16), .fail_elem(fe16), .fail_addr(fa16), .fail_data(fd16),
        .ram_wr_en(wr16), .ram_rd_en(rd16), .ram_addr(addr16), .ram_wdata(wdata16),
        .ram_rdata(rdata16)
    );

    ram_march_bist #(.DATA_WIDTH(8), .DEPTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .busy(busy10), .done(done10),
        .pass(pass10), .fail(fail10), .fail_elem(fe10), .fail_addr(fa10), .fail_data(fd10),
        .ram_wr_en(wr10), .ram_rd_en(rd10), .ram_addr(addr10), .ram_wdata(wdata10),
        .ram_rdata(rdata10)
    );

    logic       o_busy, o_done, o_pass, o_fail, o_wr, o_rd;
    logic [2:0] o_fe;
    logic [3:0] o_fa, o_addr;
    logic [7:0] o_fd, o_wdata;

    assign o_busy  = sel ? busy10  : busy16;
    assign o_done  = sel ? done10  : done16;
    assign o_pass  = sel ? pass10  : pass16;
    assign o_fail  = sel ? fail10  : fail16;
    assign o_wr    = sel ? wr10    : wr16;
    assign o_rd    = sel ? rd10    : rd16;
    assign o_fe    = sel ? fe10    : fe16;
    assign o_fa    = sel ? fa10    : fa16;
    assign o_addr  = sel ? addr10  : addr16;
    assign o_fd    = sel ? fd10    : fd16;
    assign o_wdata = sel ? wdata10 : wdata16;

    // Fault injection for the DEPTH-16 RAM: 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 coupling
    int         f_type = 0;
    logic [3:0] f_addr = '0;
    logic [3:0] f_victim = '0;
    logic [7:0] f_mask = '0;

    function automatic logic [7:0] fault_store(input logic [3:0] a, input logic [7:0] v);
        if (f_type == 1 && a == f_addr) return v | f_mask;
        if (f_type == 2 && a == f_addr) return v & ~f_mask;
        return v;
    endfunction

    logic [7:0] mem16 [16];
    logic [7:0] mem10 [10];

    always @(posedge clk) begin
        if (wr16) begin
            mem16[addr16] <= fault_store(addr16, wdata16);
            if (f_type == 3 && addr16 == f_addr && wdata16 == 8'hFF) mem16[f_victim] <= 8'h00;
        end
        if (rd16) rdata16 <= mem16[addr16];
    end

    always @(posedge clk) begin
        if (wr10 && addr10 < 4'd10) mem10[int'(addr10)] <= wdata10;
        if (rd10 && addr10 < 4'd10) rdata10 <= mem10[int'(addr10)];
    end

    int total = 0;
    int bad = 0;

    // Reference model: walks the March C- algorithm over an array memory
    int         m_cycles;
    bit         m_fail;
    logic [2:0] m_elem;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] model_mem [16];

    task automatic model_write(input int a, input logic [7:0] v, input bit faulty);
        model_mem[a] = faulty ? fault_store(4'(a), v) : v;
        if (faulty && f_type == 3 && 4'(a) == f_addr && v == 8'hFF) model_mem[f_victim] = 8'h00;
    endtask

    task automatic run_model(input int depth, input bit faulty);
        m_cycles = 0; m_fail = 0; m_elem = '0; m_addr = '0; m_data = '0;
        for (int a = 0; a < depth; a++) begin
            model_write(a, 8'h00, faulty);
            m_cycles++;
        end
        for (int e = 1; e <= 5; e++) begin
            bit desc = (e == 3 || e == 4);
            logic [7:0] rv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            logic [7:0] wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int k = 0; k < depth; k++) begin
                int a = desc ? depth - 1 - k : k;
                m_cycles += 2;
                if (model_mem[a] !== rv) begin
                    m_fail = 1; m_elem = 3'(e); m_addr = 4'(a); m_data = model_mem[a];
                    return;
                end
                if (e != 5) model_write(a, wv, faulty);
            end
        end
    endtask

    // Observations collected by do_run
    int         o_cycles, o_clash, o_done_during;
    bit         o_timeout;
    logic       o_first_wr, o_first_rd, o_first_fail, o_first_pass;
    logic [3:0] o_first_addr, o_max_addr, o_e3_addr;
    logic [7:0] o_first_wdata;
    logic       o_e3_rd, o_done_end, o_done_after, o_busy_after;
    logic       r_pass, r_fail;
    logic [2:0] r_fe;
    logic [3:0] r_fa;
    logic [7:0] r_fd;

    task automatic do_run(input int depth, input bit spurious, input bit hold);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = hold;
        o_first_wr = o_wr; o_first_rd = o_rd; o_first_addr = o_addr; o_first_wdata = o_wdata;
        o_first_fail = o_fail; o_first_pass = o_pass;
        o_cycles = 0; o_clash = 0; o_done_during = 0; o_max_addr = '0; o_e3_addr = '0; o_e3_rd = 0;
        while (o_busy === 1'b1 && o_cycles < 11 * depth + 20) begin
            o_cycles++;
            if (o_addr > o_max_addr) o_max_addr = o_addr;
            if (o_rd && o_wr) o_clash++;
            if (o_done) o_done_during++;
            if (o_cycles == 5 * depth + 1) begin o_e3_addr = o_addr; o_e3_rd = o_rd; end
            if (spurious && o_cycles < 8 * depth) start = ($urandom_range(0, 3) == 0);
            else start = hold;
            @(negedge clk);
        end
        o_timeout = (o_busy === 1'b1);
        o_done_end = o_done;
        r_pass = o_pass; r_fail = o_fail; r_fe = o_fe; r_fa = o_fa; r_fd = o_fd;
        @(negedge clk);
        o_done_after = o_done; o_busy_after = o_busy;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy16, done16, pass16, fail16, fe16, fa16, fd16, wr16, rd16, addr16, wdata16} !== '0) begin
            bad++; $display("[TB] FAIL reset16: outputs got %b want all zero",
                {busy16, done16, pass16, fail16, fe16, fa16, fd16, wr16, rd16, addr16, wdata16});
        end
        total++;
        if ({busy10, done10, pass10, fail10, fe10, fa10, fd10, wr10, rd10, addr10, wdata10} !== '0) begin
            bad++; $display("[TB] FAIL reset10: outputs got %b want all zero",
                {busy10, done10, pass10, fail10, fe10, fa10, fd10, wr10, rd10, addr10, wdata10});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fault_free();
        sel = 0; f_type = 0;
        run_model(16, 0);
        do_run(16, 0, 0);
        total++; if (o_timeout) begin bad++; $display("[TB] FAIL ff timeout: busy still %b after %0d", o_busy, o_cycles); end
        total++; if (o_cycles != m_cycles) begin bad++; $display("[TB] FAIL ff busy_len: got %0d want %0d", o_cycles, m_cycles); end
        total++; if ({o_first_wr, o_first_rd} !== 2'b10) begin bad++; $display("[TB] FAIL ff first_strobe: got %b want 10", {o_first_wr, o_first_rd}); end
        total++; if (o_first_addr !== 4'd0) begin bad++; $display("[TB] FAIL ff first_addr: got %0d want 0", o_first_addr); end
        total++; if (o_first_wdata !== 8'h00) begin bad++; $display("[TB] FAIL ff first_wdata: got %h want 00", o_first_wdata); end
        total++; if ({o_done_end, o_done_after} !== 2'b10) begin bad++; $display("[TB] FAIL ff done_pulse: got %b want 10", {o_done_end, o_done_after}); end
        total++; if (o_done_during != 0) begin bad++; $display("[TB] FAIL ff done_while_busy: got %0d want 0", o_done_during); end
        total++; if ({r_pass, r_fail} !== 2'b10) begin bad++; $display("[TB] FAIL ff pass_fail: got %b want 10", {r_pass, r_fail}); end
        total++; if (o_clash != 0) begin bad++; $display("[TB] FAIL ff strobe_clash: got %0d want 0", o_clash); end
        total++; if ({o_e3_rd, o_e3_addr} !== {1'b1, 4'd15}) begin bad++; $display("[TB] FAIL ff e3_start: got rd=%b addr=%0d want rd=1 addr=15", o_e3_rd, o_e3_addr); end
        total++; if (o_max_addr !== 4'd15) begin bad++; $display("[TB] FAIL ff max_addr: got %0d want 15", o_max_addr); end
    endtask

    task automatic test_directed_faults();
        int         d_type [3] = '{1, 2, 3};
        logic [3:0] d_addr [3] = '{4'd5, 4'd15, 4'd3};
        logic [7:0] d_mask [3] = '{8'h08, 8'h01, 8'h00};
        logic [3:0] d_vict [3] = '{4'd0, 4'd0, 4'd2};
        logic [2:0] x_elem [3] = '{3'd1, 3'd2, 3'd2};
        logic [3:0] x_addr [3] = '{4'd5, 4'd15, 4'd2};
        logic [7:0] x_data [3] = '{8'h08, 8'hFE, 8'h00};
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            f_type = d_type[i]; f_addr = d_addr[i]; f_mask = d_mask[i]; f_victim = d_vict[i];
            run_model(16, 1);
            do_run(16, 0, 0);
            total++; if ({o_first_pass, o_first_fail} !== 2'b00) begin bad++; $display("[TB] FAIL dir%0d cleared_on_start: got %b want 00", i, {o_first_pass, o_first_fail}); end
            total++; if (r_fe !== x_elem[i]) begin bad++; $display("[TB] FAIL dir%0d fail_elem: got %0d want %0d", i, r_fe, x_elem[i]); end
            total++; if (r_fa !== x_addr[i]) begin bad++; $display("[TB] FAIL dir%0d fail_addr: got %0d want %0d", i, r_fa, x_addr[i]); end
            total++; if (r_fd !== x_data[i]) begin bad++; $display("[TB] FAIL dir%0d fail_data: got %h want %h", i, r_fd, x_data[i]); end
            total++; if ({r_pass, r_fail} !== 2'b01) begin bad++; $display("[TB] FAIL dir%0d pass_fail: got %b want 01", i, {r_pass, r_fail}); end
            total++; if (o_cycles != m_cycles) begin bad++; $display("[TB] FAIL dir%0d busy_len: got %0d want %0d", i, o_cycles, m_cycles); end
            total++; if ({o_done_end, o_done_after} !== 2'b10) begin bad++; $display("[TB] FAIL dir%0d done_pulse: got %b want 10", i, {o_done_end, o_done_after}); end
        end
        f_type = 0;
    endtask

    task automatic test_random_faults();
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            f_type = int'($urandom_range(1, 3));
            f_addr = 4'($urandom_range(0, 15));
            f_mask = 8'(1 << $urandom_range(0, 7));
            do f_victim = 4'($urandom_range(0, 15)); while (f_victim == f_addr);
            run_model(16, 1);
            do_run(16, 0, 0);
            total++; if (r_fail !== m_fail) begin bad++; $display("[TB] FAIL rnd%0d fail: got %b want %b (type %0d)", i, r_fail, m_fail, f_type); end
            total++; if (r_pass !== !m_fail) begin bad++; $display("[TB] FAIL rnd%0d pass: got %b want %b", i, r_pass, !m_fail); end
            total++; if ({r_fe, r_fa, r_fd} !== {m_elem, m_addr, m_data}) begin
                bad++; $display("[TB] FAIL rnd%0d diag: got e%0d a%0d d%h want e%0d a%0d d%h",
                    i, r_fe, r_fa, r_fd, m_elem, m_addr, m_data);
            end
            total++; if (o_cycles != m_cycles) begin bad++; $display("[TB] FAIL rnd%0d busy_len: got %0d want %0d", i, o_cycles, m_cycles); end
        end
        f_type = 0;
    endtask

    task automatic test_reset_midrun();
        sel = 0; f_type = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy16, done16, pass16, fail16, fe16, fa16, fd16, wr16, rd16, addr16, wdata16} !== '0) begin
            bad++; $display("[TB] FAIL midreset outputs: got %b want all zero",
                {busy16, done16, pass16, fail16, fe16, fa16, fd16, wr16, rd16, addr16, wdata16});
        end
        @(negedge clk); rst_n = 1'b1;
        run_model(16, 0);
        do_run(16, 0, 0);
        total++; if (o_cycles != m_cycles) begin bad++; $display("[TB] FAIL midreset busy_len: got %0d want %0d", o_cycles, m_cycles); end
        total++; if ({r_pass, r_fail} !== 2'b10) begin bad++; $display("[TB] FAIL midreset pass_fail: got %b want 10", {r_pass, r_fail}); end
    endtask

    task automatic test_spurious_start();
        sel = 0; f_type = 0;
        run_model(16, 0);
        do_run(16, 1, 0);
        total++; if (o_cycles != m_cycles) begin bad++; $display("[TB] FAIL spurious busy_len: got %0d want %0d", o_cycles, m_cycles); end
        total++; if ({r_pass, r_fail, o_done_end} !== 3'b101) begin bad++; $display("[TB] FAIL spurious result: got %b want 101", {r_pass, r_fail, o_done_end}); end
        total++; if (o_busy_after !== 1'b0) begin bad++; $display("[TB] FAIL spurious retrigger: got busy %b want 0", o_busy_after); end
    endtask

    task automatic test_back_to_back();
        int n;
        sel = 0; f_type = 0;
        run_model(16, 0);
        do_run(16, 0, 1);
        total++; if ({o_done_end, r_pass} !== 2'b11) begin bad++; $display("[TB] FAIL b2b first_result: got %b want 11", {o_done_end, r_pass}); end
        total++; if (o_busy_after !== 1'b1) begin bad++; $display("[TB] FAIL b2b retrigger: got busy %b want 1", o_busy_after); end
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (o_busy !== 1'b1) break;
            n++;
        end
        total++; if (n != m_cycles) begin bad++; $display("[TB] FAIL b2b second_len: got %0d want %0d", n, m_cycles); end
        total++; if ({o_done, o_pass} !== 2'b11) begin bad++; $display("[TB] FAIL b2b second_result: got %b want 11", {o_done, o_pass}); end
    endtask

    task automatic test_depth10();
        sel = 1;
        run_model(10, 0);
        do_run(10, 0, 0);
        total++; if (o_timeout) begin bad++; $display("[TB] FAIL d10 timeout: busy still %b after %0d", o_busy, o_cycles); end
        total++; if (o_max_addr !== 4'd9) begin bad++; $display("[TB] FAIL d10 max_addr: got %0d want 9", o_max_addr); end
        total++; if (o_cycles != m_cycles) begin bad++; $display("[TB] FAIL d10 busy_len: got %0d want %0d", o_cycles, m_cycles); end
        total++; if ({o_e3_rd, o_e3_addr} !== {1'b1, 4'd9}) begin bad++; $display("[TB] FAIL d10 e3_start: got rd=%b addr=%0d want rd=1 addr=9", o_e3_rd, o_e3_addr); end
        total++; if ({r_pass, r_fail, o_done_end} !== 3'b101) begin bad++; $display("[TB] FAIL d10 result: got %b want 101", {r_pass, r_fail, o_done_end}); end
        sel = 0;
    endtask

    initial begin
        $display("[TB] starting ram_march_bist bench");
        test_reset();
        test_fault_free();
        test_directed_faults();
        test_random_faults();
        test_reset_midrun();
        test_spurious_start();
        test_back_to_back();
        test_depth10();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
